// File: rtl/counter.sv
// counter: free-running modulo up-counter (0..MAX_VAL, then wrap to 0)
// with a terminal-count decode.
// Optional build macro COUNTER_GRAY_OUT_EN adds a registered Gray-code copy
// of the count (count_gray). It is aligned cycle-for-cycle with count.
// Any out-of-range count value is treated as terminal, so the next edge
// always loads 0 and the counter cannot lock up.
module counter #(
    parameter int          WIDTH   = 3,
    parameter int unsigned MAX_VAL = 7
) (
    input  logic             Clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] count,
    output logic             tc
`ifdef COUNTER_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] count_gray
`endif
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-state: wrap at MAX_VAL; anything above MAX_VAL also recovers to 0.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        if (count_q >= MAX_Q) begin
            count_d = '0;
        end
    end

    // Count register; asynchronous clear, restarts from 0 after release.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // Decoded from the register, so it clears together with the async reset.
    assign tc    = (count_q == MAX_Q);

`ifdef COUNTER_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q;

    // Encode the next binary value so gray_q lines up with count_q.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            gray_q <= '0;
        end else begin
            gray_q <= count_d ^ (count_d >> 1);
        end
    end

    assign count_gray = gray_q;
`endif

endmodule

// File: tb/tb_counter.sv
// Bench for counter: a default instance (WIDTH=3, MAX_VAL=7) and a
// non-power-of-two instance (WIDTH=3, MAX_VAL=5) share clock and reset.
// A reference model pushes expected values at each rising edge; they are
// popped and compared on the following falling edge.
module tb_counter;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic [2:0] count;
    logic       tc;
    logic [2:0] count5;
    logic       tc5;
`ifdef COUNTER_GRAY_OUT_EN
    logic [2:0] count_gray;
    logic [2:0] count_gray5;
    logic [2:0] prev_g;
`endif

    always #10 Clk = ~Clk;

    counter #(.WIDTH(3), .MAX_VAL(7)) u_dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .count      (count),
        .tc         (tc)
`ifdef COUNTER_GRAY_OUT_EN
        ,
        .count_gray (count_gray)
`endif
    );

    counter #(.WIDTH(3), .MAX_VAL(5)) u_dut5 (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .count      (count5),
        .tc         (tc5)
`ifdef COUNTER_GRAY_OUT_EN
        ,
        .count_gray (count_gray5)
`endif
    );

    typedef struct packed {
        logic [2:0] c;
        logic       t;
        logic [2:0] c5;
        logic       t5;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] m;
    logic [2:0] m5;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n clock cycles: predict at posedge, compare at the next negedge.
    task automatic step(input int n);
        exp_t e;
        exp_t got;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            m  = (m  >= 3'd7) ? 3'd0 : m  + 3'd1;
            m5 = (m5 >= 3'd5) ? 3'd0 : m5 + 3'd1;
            e.c  = m;
            e.t  = (m == 3'd7);
            e.c5 = m5;
            e.t5 = (m5 == 3'd5);
            sb.push_back(e);
            @(negedge Clk);
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                check("count",  {29'd0, count},  {29'd0, got.c});
                check("tc",     {31'd0, tc},     {31'd0, got.t});
                check("count5", {29'd0, count5}, {29'd0, got.c5});
                check("tc5",    {31'd0, tc5},    {31'd0, got.t5});
`ifdef COUNTER_GRAY_OUT_EN
                check("gray",  {29'd0, count_gray},  {29'd0, got.c ^ (got.c >> 1)});
                check("gray5", {29'd0, count_gray5}, {29'd0, got.c5 ^ (got.c5 >> 1)});
                check("gray_onebit", $countones(count_gray ^ prev_g), 32'd1);
                prev_g = count_gray;
`endif
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        m  = 3'd0;
        m5 = 3'd0;
`ifdef COUNTER_GRAY_OUT_EN
        prev_g = 3'd0;
`endif
        // Hold reset across several clock edges.
        #1;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_tc",    {31'd0, tc},    32'd0);
        repeat (5) begin
            @(posedge Clk);
            #1;
            check("rst_hold_count",  {29'd0, count},  32'd0);
            check("rst_hold_tc",     {31'd0, tc},     32'd0);
            check("rst_hold_count5", {29'd0, count5}, 32'd0);
        end
        // Now t=91; release at t=100, between edges.
        #9;
        reset_n = 1'b1;
        #1;
        check("release_count", {29'd0, count}, 32'd0);
        check("release_tc",    {31'd0, tc},    32'd0);

        // Count through several full wraps.
        step(30);

        // Run until the default counter sits at 5, then reset mid-cycle.
        for (int k = 0; k < 10 && m != 3'd5; k++) step(1);
        check("pre_reset_count", {29'd0, count}, 32'd5);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_clr_count",  {29'd0, count},  32'd0);
        check("async_clr_tc",     {31'd0, tc},     32'd0);
        check("async_clr_count5", {29'd0, count5}, 32'd0);
`ifdef COUNTER_GRAY_OUT_EN
        check("async_clr_gray", {29'd0, count_gray}, 32'd0);
        prev_g = 3'd0;
`endif
        m  = 3'd0;
        m5 = 3'd0;
        repeat (2) begin
            @(posedge Clk);
            #1;
            check("rst_mid_hold", {29'd0, count}, 32'd0);
        end
        @(negedge Clk);
        #5;
        reset_n = 1'b1;
        #1;
        check("rerelease_count", {29'd0, count}, 32'd0);
        step(12);

        // Plant an illegal value in the MAX_VAL=5 counter; it must recover to 0.
        for (int k = 0; k < 10 && m5 != 3'd2; k++) step(1);
        force u_dut5.count_q = 3'd6;
        #1;
        release u_dut5.count_q;
        #1;
        check("forced_count5", {29'd0, count5}, 32'd6);
        check("forced_tc5",    {31'd0, tc5},    32'd0);
        m5 = 3'd6;
        step(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #50000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Free-running synchronous up-counter with modulo wrap.
- Counts 0..MAX_VAL on every rising clock edge, then wraps to 0.
- Used as a basic timebase/sequence generator; it has no enable or load, and runs whenever reset is deasserted.
- Provides a terminal-count flag for cascading or downstream event generation.

Parameters:
- WIDTH, 3, bit width of the count output; legal range 1..32.
- MAX_VAL, 7, last value before wrap; must satisfy 0 < MAX_VAL <= 2^WIDTH-1.

Ports:
- Clk  input  1  rising-edge clock; the block's only clock.
- reset_n  input  1  asynchronous, active-low reset.
- count  output  WIDTH  current counter value, registered.
- tc  output  1  terminal count, high while count == MAX_VAL.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low (reset_n).
- Reset:
  - reset_n low forces count = 0 immediately, independent of Clk.
  - count stays at 0 while reset_n is held low.
  - Reset values: count = 0, tc = 0 (given MAX_VAL > 0).
- Release:
  - Deassertion needs no synchronization inside the block.
  - count holds 0 until the first rising Clk edge with reset_n high.
  - That edge loads 1.
- Counting:
  - On each rising Clk edge with reset_n high: if count == MAX_VAL, next count = 0; otherwise next count = count + 1.
  - Single-cycle latency. count is a direct register output, with no combinational path from any input except the async reset.
- Wrap: for the defaults the sequence is 0,1,2,3,4,5,6,7,0,1,... Period is MAX_VAL+1 cycles.
- Non-power-of-two MAX_VAL (e.g. 5 with WIDTH=3): values above MAX_VAL are never produced.
- Illegal states: if count ever holds a value > MAX_VAL, the next edge loads 0. There is no lockup.
- tc:
  - Combinational decode of the registered count; high exactly one cycle per period.
  - Goes low asynchronously with reset.
- Reset mid-operation: count clears to 0 at the reset_n falling edge, even mid-cycle. After release it restarts from 0 as on power-up.
- Reset_n rising coincident with Clk rising: either outcome (0 or 1 after that edge) is acceptable. Benches shall not release reset on a clock edge.
- No X propagation: all outputs are defined after the first reset assertion.

Optional Feature:
- Macro: COUNTER_GRAY_OUT_EN.
- Defined:
  - Adds output port count_gray [WIDTH-1:0], a registered Gray-code encoding of the next binary value. It equals count ^ (count >> 1), aligned cycle-for-cycle with count.
  - count_gray resets asynchronously to 0.
  - Only meaningful when MAX_VAL = 2^WIDTH-1; otherwise it still encodes count, but adjacent-bit-change is not guaranteed at wrap.
- Not defined: the port and its register do not exist; count and tc behaviour is unchanged.

Test Plan:
- Hold reset_n=0 for 100 ns with a 20 ns clock -> count=0 and tc=0 throughout, including across clock edges.
- Release reset_n at t=100 ns (between edges) -> count=0 immediately after release; count=1 after the first posedge (t=110 ns); then 2,3,...,7 on successive edges.
- Continue past 7 -> next edge gives 0, then 1. tc high only while count=7. Run 500 ns with zero mismatches against the reference model.
- Assert reset_n=0 mid-cycle while count=5 -> count=0 within the same time step, with no clock needed. Release -> restarts 0,1,2...
- WIDTH=3, MAX_VAL=5 -> sequence 0..5,0, and tc high at 5. Force count=6 -> next edge gives 0.
- With COUNTER_GRAY_OUT_EN defined -> count_gray follows 0,1,3,2,6,7,5,4,0, and exactly one bit toggles per edge, including the 7→0 wrap.
